// File: rtl/pam_rx_pkg.sv
// Shared types and elaboration-time helpers for the PAM receive back end:
// width math, FSM state encoding and the Gray-to-binary decoder.
package pam_rx_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Counter width that never collapses to zero bits for tiny parameters.
  function automatic int cnt_width(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

  function automatic int bps_of(input int pam_order);
    return clog2(pam_order);
  endfunction

  function automatic int spw_of(input int data_width, input int pam_order);
    return data_width / bps_of(pam_order);
  endfunction

  // Binary bit i is the XOR of all Gray bits at or above i; unused upper bits are zero.
  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/pam_demap_packer_if.sv
// AXI-stream output bundle of the PAM demapper/packer.
interface pam_demap_packer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/pam_slicer.sv
// Hard-decision PAM slicer: keeps the top BPS bits of an offset-binary sample.
// With PAM_GRAY_DECODE_EN defined, the sliced level is Gray-to-binary decoded.
module pam_slicer
  import pam_rx_pkg::*;
#(
  parameter int PAM_ORDER     = 4,
  parameter int AD_CVER_WIDTH = 12,
  localparam int BPS          = bps_of(PAM_ORDER)
) (
  input  logic [AD_CVER_WIDTH-1:0] sym_data,
  output logic [BPS-1:0]           sym
);

  logic [BPS-1:0] raw_sym;

  // Upper bits of an offset-binary sample; a value on a k*2^W/M boundary lands in the upper level.
  assign raw_sym = BPS'(sym_data >> (AD_CVER_WIDTH - BPS));

`ifdef PAM_GRAY_DECODE_EN
  assign sym = BPS'(gray2bin(4'(raw_sym)));
`else
  assign sym = raw_sym;
`endif

endmodule

// File: rtl/pam_demap_packer.sv
// PAM receive back end: slices samples to symbols, packs them MSB-first into words,
// frames LENGTH_DATA words with tlast and buffers them in a small output FIFO.
// Optional Gray decoding of the sliced symbol is enabled by PAM_GRAY_DECODE_EN.
module pam_demap_packer
  import pam_rx_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int PAM_ORDER     = 4,
  parameter int AD_CVER_WIDTH = 12,
  parameter int LENGTH_DATA   = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     frame_start,
  input  logic                     sym_valid,
  input  logic [AD_CVER_WIDTH-1:0] sym_data,
  pam_demap_packer_if.master       m_axi,
  output logic                     busy,
  output logic                     overflow
);

  localparam int BPS = bps_of(PAM_ORDER);
  localparam int SPW = spw_of(DATA_WIDTH, PAM_ORDER);
  localparam int SCW = cnt_width(SPW);
  localparam int WCW = cnt_width(LENGTH_DATA);
  localparam int AW  = cnt_width(FIFO_DEPTH);
  localparam int EW  = DATA_WIDTH + 1;
  localparam int KW  = DATA_WIDTH / 8;

  localparam logic [SCW-1:0] LAST_SYM  = SCW'(SPW - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(LENGTH_DATA - 1);
  localparam logic [AW:0]    FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  state_t                state_q, state_d;
  logic [SCW-1:0]        sym_cnt_q, sym_cnt_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  overflow_q, overflow_d;
  logic [EW-1:0]         mem_q [1 << AW];
  logic [EW-1:0]         mem_d [1 << AW];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;

  logic [BPS-1:0]        sym;
  logic                  take;
  logic                  push_req;
  logic                  push_last;
  logic                  push_ok;
  logic                  pop;
  logic                  out_valid;
  logic [SCW-1:0]        base_sym;
  logic [WCW-1:0]        base_word;
  logic [DATA_WIDTH-1:0] base_shift;
  logic [DATA_WIDTH-1:0] packed_word;
  logic [EW-1:0]         head;

  pam_slicer #(
    .PAM_ORDER    (PAM_ORDER),
    .AD_CVER_WIDTH(AD_CVER_WIDTH)
  ) u_slicer (
    .sym_data(sym_data),
    .sym     (sym)
  );

  // frame_start restarts packing from a clean word, so a coincident sample becomes symbol 0.
  always_comb begin
    base_sym    = frame_start ? '0 : sym_cnt_q;
    base_word   = frame_start ? '0 : word_cnt_q;
    base_shift  = frame_start ? '0 : shift_q;
    take        = sym_valid && (frame_start || (state_q == RUN));
    packed_word = DATA_WIDTH'({base_shift, sym});

    state_d    = frame_start ? RUN : state_q;
    sym_cnt_d  = base_sym;
    word_cnt_d = base_word;
    shift_d    = base_shift;
    push_req   = 1'b0;
    push_last  = 1'b0;

    if (take) begin
      shift_d = packed_word;
      if (base_sym == LAST_SYM) begin
        push_req  = 1'b1;
        sym_cnt_d = '0;
        if (base_word == LAST_WORD) begin
          push_last  = 1'b1;
          word_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          word_cnt_d = base_word + WCW'(1);
        end
      end else begin
        sym_cnt_d = base_sym + SCW'(1);
      end
    end
  end

  // A word that meets a full FIFO is lost but still counted; a same-cycle pop frees the slot.
  always_comb begin
    pop        = (count_q != '0) && m_axi.tready;
    push_ok    = push_req && ((count_q != FULL_CNT) || pop);
    overflow_d = frame_start ? 1'b0 : overflow_q;
    if (push_req && !push_ok) overflow_d = 1'b1;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = {push_last, packed_word};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      sym_cnt_q  <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Outputs are forced to zero while empty so that reset drops them without waiting for a clock.
  assign head         = mem_q[rd_ptr_q];
  assign out_valid    = (count_q != '0);
  assign m_axi.tvalid = out_valid;
  assign m_axi.tdata  = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_axi.tlast  = out_valid ? head[EW-1] : 1'b0;
  assign m_axi.tkeep  = out_valid ? {KW{1'b1}} : '0;
  assign busy         = (state_q == RUN);
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_pam_demap_packer.sv
// Self-checking bench for pam_demap_packer: directed scenarios plus randomized frames
// scored against a sample-level reference model of slicing, packing and framing.
module tb_pam_demap_packer;

  localparam int DATA_WIDTH  = 32;
  localparam int PAM_ORDER   = 4;
  localparam int AD_W        = 12;
  localparam int LENGTH_DATA = 32;
  localparam int FIFO_DEPTH  = 4;
  localparam int SPW         = 16;

`ifdef PAM_GRAY_DECODE_EN
  localparam logic [31:0] PATTERN_WORD = 32'h1E1E1E1E;
`else
  localparam logic [31:0] PATTERN_WORD = 32'h1B1B1B1B;
`endif

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic            clk = 1'b0;
  logic            arst = 1'b1;
  logic            frame_start = 1'b0;
  logic            sym_valid = 1'b0;
  logic [AD_W-1:0] sym_data = '0;
  logic            busy;
  logic            overflow;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  int          model_syms[$];
  int          model_in_frame = 0;
  int          model_words = 0;
  bit          mon_en = 1'b0;
  int          words_seen = 0;
  int          lasts_seen = 0;
  logic [31:0] last_word = '0;
  int          pattern_samples[4] = '{0, 'h400, 'h800, 'hC00};

  pam_demap_packer_if #(.DATA_WIDTH(DATA_WIDTH)) axi ();

  pam_demap_packer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .PAM_ORDER    (PAM_ORDER),
    .AD_CVER_WIDTH(AD_W),
    .LENGTH_DATA  (LENGTH_DATA),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .frame_start(frame_start),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
    .m_axi      (axi),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Level index from the decision boundaries; Gray mode finds the binary value whose Gray code is that level.
  function automatic int model_sym(input int sample);
    int lvl;
    lvl = sample / ((1 << AD_W) / PAM_ORDER);
`ifdef PAM_GRAY_DECODE_EN
    for (int b = 0; b < PAM_ORDER; b++) begin
      if ((b ^ (b >> 1)) == lvl) return b;
    end
`endif
    return lvl;
  endfunction

  function automatic void model_step(input bit fs, input bit sv, input int sample);
    longint w;
    exp_t   e;
    if (fs) begin
      model_in_frame = 1;
      model_words    = 0;
      model_syms.delete();
    end
    if (sv && (model_in_frame != 0)) begin
      model_syms.push_back(model_sym(sample));
      if (model_syms.size() == SPW) begin
        w = 0;
        foreach (model_syms[i]) w = w * PAM_ORDER + model_syms[i];
        model_words++;
        e.data = w[31:0];
        e.last = (model_words == LENGTH_DATA);
        exp_q.push_back(e);
        model_syms.delete();
        if (e.last) begin
          model_in_frame = 0;
          model_words    = 0;
        end
      end
    end
  endfunction

  task automatic applyStimulus(input bit fs, input bit sv, input int sample);
    frame_start = fs;
    sym_valid   = sv;
    sym_data    = AD_W'(sample);
    model_step(fs, sv, sample);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    sym_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 0);
  endtask

  // Scoreboard: every accepted beat is compared with the oldest predicted word.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !arst && axi.tvalid && axi.tready) begin
      words_seen++;
      last_word = axi.tdata;
      if (axi.tlast) lasts_seen++;
      checkOutput("axis_tkeep", 64'(axi.tkeep), 64'hF);
      checkOutput("word_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("axis_tdata", 64'(axi.tdata), 64'(e.data));
        checkOutput("axis_tlast", 64'(axi.tlast), 64'(e.last));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ws0;

    axi.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tvalid", 64'(axi.tvalid), 64'd0);
    checkOutput("reset_tkeep", 64'(axi.tkeep), 64'd0);
    checkOutput("reset_tlast", 64'(axi.tlast), 64'd0);
    checkOutput("reset_tdata", 64'(axi.tdata), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_overflow", 64'(overflow), 64'd0);
    arst = 1'b0;
    idle(2);

    $display("[TB] pattern frame");
    mon_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("busy_after_frame_start", 64'(busy), 64'd1);
    for (int i = 0; i < LENGTH_DATA * SPW; i++) applyStimulus(1'b0, 1'b1, pattern_samples[i % 4]);
    checkOutput("busy_after_last_word", 64'(busy), 64'd0);
    idle(4);
    checkOutput("pattern_word_count", 64'(words_seen), 64'd32);
    checkOutput("pattern_tlast_count", 64'(lasts_seen), 64'd1);
    checkOutput("pattern_word_value", 64'(last_word), 64'(PATTERN_WORD));
    checkOutput("pattern_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] slicer boundaries");
    applyStimulus(1'b1, 1'b0, 0);
    for (int i = 0; i < SPW; i++) applyStimulus(1'b0, 1'b1, ((i % 2) == 0) ? 'h3FF : 'h400);
    idle(3);
    checkOutput("boundary_word", 64'(last_word), 64'h11111111);

    $display("[TB] re-sync");
    ws0 = words_seen;
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 'hC00);
    applyStimulus(1'b1, 1'b1, 0);
    for (int i = 0; i < SPW - 1; i++) applyStimulus(1'b0, 1'b1, 0);
    idle(3);
    checkOutput("resync_word_count", 64'(words_seen - ws0), 64'd1);
    checkOutput("resync_first_word", 64'(last_word), 64'd0);

    $display("[TB] gapped input");
    applyStimulus(1'b1, 1'b0, 0);
    for (int w = 0; w < 2; w++) begin
      for (int s = 0; s < SPW; s++) begin
        if (s == SPW - 1) checkOutput("gap_tvalid_before", 64'(axi.tvalid), 64'd0);
        applyStimulus(1'b0, 1'b1, int'($urandom_range(0, 4095)));
        if (s == SPW - 1) checkOutput("gap_tvalid_latency", 64'(axi.tvalid), 64'd1);
        idle(2);
      end
    end
    checkOutput("gap_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] randomized traffic");
    applyStimulus(1'b1, 1'b0, 0);
    for (int c = 0; c < 1200; c++) begin
      axi.tready = ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)));
    end
    axi.tready = 1'b1;
    idle(10);
    checkOutput("random_queue_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("random_no_overflow", 64'(overflow), 64'd0);

    $display("[TB] back-pressure");
    mon_en = 1'b0;
    exp_q.delete();
    axi.tready = 1'b0;
    applyStimulus(1'b1, 1'b0, 0);
    for (int i = 0; i < 5 * SPW; i++) applyStimulus(1'b0, 1'b1, int'($urandom_range(0, 4095)));
    checkOutput("bp_overflow", 64'(overflow), 64'd1);
    checkOutput("bp_tvalid", 64'(axi.tvalid), 64'd1);
    for (int c = 0; c < 3; c++) begin
      checkOutput("bp_stall_tdata", 64'(axi.tdata), 64'(exp_q[0].data));
      idle(1);
    end
    axi.tready = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      checkOutput("bp_drain_tdata", 64'(axi.tdata), 64'(exp_q[i].data));
      checkOutput("bp_drain_tlast", 64'(axi.tlast), 64'd0);
      idle(1);
    end
    checkOutput("bp_empty_after_drain", 64'(axi.tvalid), 64'd0);
    checkOutput("bp_overflow_sticky", 64'(overflow), 64'd1);
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("bp_overflow_cleared", 64'(overflow), 64'd0);

    $display("[TB] reset mid-frame");
    exp_q.delete();
    axi.tready = 1'b0;
    for (int i = 0; i < 10 * SPW; i++) applyStimulus(1'b0, 1'b1, int'($urandom_range(0, 4095)));
    checkOutput("rst_tvalid_before", 64'(axi.tvalid), 64'd1);
    checkOutput("rst_overflow_before", 64'(overflow), 64'd1);
    @(negedge clk);
    arst = 1'b1;
    #1;
    checkOutput("rst_tvalid_async", 64'(axi.tvalid), 64'd0);
    checkOutput("rst_tkeep_async", 64'(axi.tkeep), 64'd0);
    checkOutput("rst_busy_async", 64'(busy), 64'd0);
    checkOutput("rst_overflow_async", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    axi.tready = 1'b1;
    exp_q.delete();
    model_syms.delete();
    model_in_frame = 0;
    model_words = 0;
    mon_en = 1'b1;
    ws0 = words_seen;
    for (int i = 0; i < 2 * SPW; i++) applyStimulus(1'b0, 1'b1, int'($urandom_range(0, 4095)));
    idle(3);
    checkOutput("rst_no_output_words", 64'(words_seen - ws0), 64'd0);
    checkOutput("rst_tvalid_idle", 64'(axi.tvalid), 64'd0);
    checkOutput("rst_busy_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
